// File: rtl/udma_jtag_fifo_pkg.sv
// Shared definitions for the uDMA JTAG FIFO setup channel: setup word layout
// and the TCK-side launch FSM encoding.
package udma_jtag_fifo_pkg;

  localparam int unsigned SETUP_WIDTH       = 57;

  localparam int unsigned SETUP_DSIZE_BEGIN = 55;
  localparam int unsigned SETUP_DSIZE_END   = 56;
  localparam int unsigned SETUP_TXRXN       = 54;
  localparam int unsigned SETUP_ADDR_BEGIN  = 22;
  localparam int unsigned SETUP_ADDR_END    = 53;
  localparam int unsigned SETUP_SIZE_BEGIN  = 0;
  localparam int unsigned SETUP_SIZE_END    = 21;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } setup_tx_state_e;

endpackage

// File: rtl/udma_jtag_fifo_sync2.sv
// Two-flop level synchronizer with asynchronous reset to 0.
module udma_jtag_fifo_sync2 (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic data_async,
  output logic data_sync
);

  logic [1:0] sync_r;

  // Metastability filter chain
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], data_async};
    end
  end

  assign data_sync = sync_r[1];

endmodule

// File: rtl/udma_jtag_fifo_setup_tx.sv
// TCK-side initiator: shifts a setup word in serially and launches it to the
// uDMA domain with a toggle/ack handshake, holding it stable until acknowledged.
module udma_jtag_fifo_setup_tx
  import udma_jtag_fifo_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   shift_en_i,
  input  logic                   shift_data_i,
  output logic                   shift_data_o,
  input  logic                   update_i,
  output logic [SETUP_WIDTH-1:0] setup_value_o,
  output logic                   setup_valid_o,
  input  logic                   setup_ack_i,
  output logic                   busy_o,
  output logic                   overrun_o,
  input  logic                   clr_overrun_i,
  output logic [CNT_WIDTH-1:0]   done_cnt_o
);

  logic [SETUP_WIDTH-1:0] sr_r;
  logic [SETUP_WIDTH-1:0] setup_value_r;
  logic                   setup_valid_r;
  logic                   overrun_r;
  logic [CNT_WIDTH-1:0]   done_cnt_r;
  setup_tx_state_e        state_r;
  logic                   ack_sync_s;

  udma_jtag_fifo_sync2 i_ack_sync (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .data_async (setup_ack_i),
    .data_sync  (ack_sync_s)
  );

  // Serial shift register, LSB-first; a concurrent update drops the shift
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sr_r <= {SETUP_WIDTH{1'b0}};
    end else if (shift_en_i && !update_i) begin
      sr_r <= {shift_data_i, sr_r[SETUP_WIDTH-1:1]};
    end
  end

  // Launch/acknowledge FSM with its registered handshake outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r       <= ST_IDLE;
      setup_value_r <= {SETUP_WIDTH{1'b0}};
      setup_valid_r <= 1'b0;
      done_cnt_r    <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (update_i) begin
            setup_value_r <= sr_r;
            setup_valid_r <= ~setup_valid_r;
            state_r       <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // Handshake closes once the synchronized ack level catches up
          if (ack_sync_s == setup_valid_r) begin
            done_cnt_r <= done_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overrun_r <= 1'b0;
    end else if (update_i && (state_r == ST_WAIT_ACK)) begin
      overrun_r <= 1'b1;
    end else if (clr_overrun_i) begin
      overrun_r <= 1'b0;
    end
  end

  assign shift_data_o  = sr_r[0];
  assign setup_value_o = setup_value_r;
  assign setup_valid_o = setup_valid_r;
  assign busy_o        = (state_r == ST_WAIT_ACK);
  assign overrun_o     = overrun_r;
  assign done_cnt_o    = done_cnt_r;

endmodule

// File: tb/tb_udma_jtag_fifo_setup_tx.sv
// Randomized bench for udma_jtag_fifo_setup_tx against a transaction-level
// model of the shift history, handshake state and counters.
module tb_udma_jtag_fifo_setup_tx;

  logic        clk;
  logic        rstn;
  logic        shift_en;
  logic        shift_data;
  logic        sdo;
  logic        update;
  logic [56:0] setup_value;
  logic        setup_valid;
  logic        setup_ack;
  logic        busy;
  logic        overrun;
  logic        clr_overrun;
  logic [7:0]  done_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // receiver model: acks recv_lat cycles after it first sees a pending request
  int          recv_lat = 0;
  int          recv_cnt;
  logic [56:0] rx_q[$];

  // reference model
  bit          bits_q[$];
  logic [56:0] m_value;
  logic        m_valid;
  logic        m_busy;
  logic        m_overrun;
  int          m_cnt;
  logic [56:0] exp_rx[$];

  udma_jtag_fifo_setup_tx dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .shift_en_i    (shift_en),
    .shift_data_i  (shift_data),
    .shift_data_o  (sdo),
    .update_i      (update),
    .setup_value_o (setup_value),
    .setup_valid_o (setup_valid),
    .setup_ack_i   (setup_ack),
    .busy_o        (busy),
    .overrun_o     (overrun),
    .clr_overrun_i (clr_overrun),
    .done_cnt_o    (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      setup_ack <= 1'b0;
      recv_cnt  <= 0;
    end else if (setup_valid != setup_ack) begin
      if (recv_cnt >= recv_lat) begin
        setup_ack <= setup_valid;
        rx_q.push_back(setup_value);
        recv_cnt  <= 0;
      end else begin
        recv_cnt <= recv_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // word = the last 57 bits shifted, most recent at bit 56, unfilled bits 0
  function automatic logic [56:0] model_word();
    logic [56:0] w;
    int n;
    w = 57'd0;
    n = bits_q.size();
    for (int k = 0; k < n; k++) w[56-k] = bits_q[n-1-k];
    return w;
  endfunction

  task automatic model_reset();
    bits_q.delete();
    exp_rx.delete();
    m_value   = 57'd0;
    m_valid   = 1'b0;
    m_busy    = 1'b0;
    m_overrun = 1'b0;
    m_cnt     = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_value"},   setup_value, m_value);
    check({tag, "_valid"},   setup_valid, m_valid);
    check({tag, "_busy"},    busy,        m_busy);
    check({tag, "_overrun"}, overrun,     m_overrun);
    check({tag, "_cnt"},     done_cnt,    m_cnt[7:0]);
  endtask

  task automatic shift_word(input logic [56:0] w);
    for (int i = 0; i < 57; i++) begin
      shift_en   = 1'b1;
      shift_data = w[i];
      @(posedge clk); #1;
      bits_q.push_back(w[i]);
      if (bits_q.size() > 57) void'(bits_q.pop_front());
    end
    shift_en = 1'b0;
    check("sdo", sdo, model_word() & 57'd1);
  endtask

  task automatic launch(input bit with_shift, input bit with_clr, input string tag);
    update      = 1'b1;
    shift_en    = with_shift;
    shift_data  = 1'($urandom);
    clr_overrun = with_clr;
    @(posedge clk); #1;
    update      = 1'b0;
    shift_en    = 1'b0;
    clr_overrun = 1'b0;
    if (!m_busy) begin
      m_value = model_word();
      m_valid = ~m_valid;
      m_busy  = 1'b1;
      exp_rx.push_back(m_value);
    end else begin
      m_overrun = 1'b1;
    end
    check_outputs(tag);
  endtask

  // exp_lat: edges after the update edge until busy is seen low
  task automatic wait_idle(input bit chk_lat, input int exp_lat, input string tag);
    int c;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (busy && c < 500);
    check({tag, "_busy_fall"}, busy, 1'b0);
    if (chk_lat) check({tag, "_latency"}, c, exp_lat);
    m_busy = 1'b0;
    m_cnt  = (m_cnt + 1) % 256;
    check_outputs(tag);
    if (rx_q.size() == 0) check({tag, "_rx_present"}, 0, 1);
    else check({tag, "_rx_word"}, rx_q.pop_front(), exp_rx.pop_front());
  endtask

  function automatic logic [56:0] rand_word();
    return {25'($urandom), $urandom};
  endfunction

  initial begin
    logic [56:0] w;
    int lat;
    rstn = 1'b0; shift_en = 1'b0; shift_data = 1'b0; update = 1'b0; clr_overrun = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset_sdo", sdo, 1'b0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // shift and launch of the reference word; ack toggles 5 edges after update
    w = {2'd0, 1'b1, 32'h1C000123, 22'h40};
    recv_lat = 4;
    shift_word(w);
    check("ref_word_model", model_word(), w);
    launch(1'b0, 1'b0, "ref");
    wait_idle(1'b1, recv_lat + 4, "ref");

    // random words, random receiver latency, back-to-back relaunch
    for (int t = 0; t < 6; t++) begin
      recv_lat = $urandom_range(0, 6);
      shift_word(rand_word());
      launch(1'b0, 1'b0, "rnd");
      wait_idle(1'b1, recv_lat + 4, "rnd");
      launch(1'b0, 1'b0, "b2b");
      wait_idle(1'b1, recv_lat + 4, "b2b");
    end

    // overrun while waiting, then clear and set-beats-clear
    recv_lat = 150;
    shift_word(rand_word());
    launch(1'b0, 1'b0, "ovr_first");
    shift_word(rand_word());
    launch(1'b0, 1'b0, "ovr_hit");
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    m_overrun = 1'b0;
    check_outputs("ovr_clr");
    launch(1'b0, 1'b1, "ovr_setclr");
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    m_overrun = 1'b0;
    check_outputs("ovr_clr2");
    wait_idle(1'b0, 0, "ovr_done");

    // shift and update together: launch the pre-cycle contents, sr untouched
    recv_lat = 2;
    w = rand_word();
    shift_word(w);
    launch(1'b1, 1'b0, "prio");
    check("prio_value", setup_value, w);
    check("prio_sdo", sdo, w & 57'd1);
    wait_idle(1'b1, recv_lat + 4, "prio");
    launch(1'b0, 1'b0, "prio_again");
    check("prio_sr_kept", setup_value, w);
    wait_idle(1'b1, recv_lat + 4, "prio_again");

    // reset in the middle of a transfer
    recv_lat = 30;
    shift_word(rand_word());
    launch(1'b0, 1'b0, "rst_pre");
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_mid");
    check("rst_sdo", sdo, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    rx_q.delete();
    recv_lat = 3;
    shift_word(rand_word());
    launch(1'b0, 1'b0, "post_rst");
    wait_idle(1'b1, recv_lat + 4, "post_rst");

    // counter wrap: 256 transfers from a fresh reset
    rstn = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    rx_q.delete();
    recv_lat = 0;
    w = rand_word();
    shift_word(w);
    for (int t = 0; t < 256; t++) begin
      lat = recv_lat + 4;
      launch(1'b0, 1'b0, "wrap");
      wait_idle(1'b1, lat, "wrap");
      if (t == 254) check("wrap_255", done_cnt, 8'd255);
    end
    check("wrap_zero", done_cnt, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
